// File: rtl/croc_boot_ctrl.sv
// Board-level boot sequencer for croc on FPGA: conditions the reset button and fetch switch,
// sequences SoC reset release and fetch enable, and divides the system clock for the RTC.
module croc_boot_ctrl #(
  parameter int unsigned DebounceCycles   = 20000,
  parameter int unsigned ResetHoldCycles  = 64,
  parameter int unsigned FetchDelayCycles = 16,
  parameter int unsigned RtcDiv           = 610
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_reset_i,
  input  logic       sw_fetch_en_i,
  output logic       soc_rst_no,
  output logic       soc_fetch_en_o,
  output logic       rtc_clk_o,
  output logic [1:0] state_o,
  output logic [7:0] rst_count_o
);

  localparam logic [1:0] ST_HOLD = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam int unsigned DbW    = (DebounceCycles > 2) ? $clog2(DebounceCycles) : 1;
  localparam int unsigned SeqMax = (ResetHoldCycles > FetchDelayCycles) ? ResetHoldCycles
                                                                       : FetchDelayCycles;
  localparam int unsigned SeqW   = (SeqMax > 1) ? $clog2(SeqMax) : 1;
  localparam int unsigned RtcW   = (RtcDiv > 0) ? $clog2(RtcDiv + 1) : 1;

  // Bit 0 carries the button path, bit 1 the fetch switch path.
  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           db_q, db_d;
  logic [1:0][DbW-1:0]  db_cnt_q, db_cnt_d;

  logic [1:0]           state_q, state_d;
  logic [SeqW-1:0]      seq_cnt_q, seq_cnt_d;
  logic                 btn_rise;

  logic [RtcW-1:0]      rtc_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {sw_fetch_en_i, btn_reset_i};
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DbW'(DebounceCycles - 1)) begin
          db_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_q     <= '0;
      db_cnt_q <= '0;
    end else begin
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Edge detection uses the next debounced value so outputs react on the same edge.
  assign btn_rise = db_d[0] & ~db_q[0];

  always_comb begin
    state_d   = state_q;
    seq_cnt_d = seq_cnt_q;
    if (btn_rise) begin
      state_d   = ST_HOLD;
      seq_cnt_d = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (db_q[0]) begin
            seq_cnt_d = '0;
          end else if (seq_cnt_q == SeqW'(ResetHoldCycles - 1)) begin
            state_d   = ST_WAIT;
            seq_cnt_d = '0;
          end else begin
            seq_cnt_d = seq_cnt_q + SeqW'(1);
          end
        end
        ST_WAIT: begin
          if (seq_cnt_q == SeqW'(FetchDelayCycles - 1)) begin
            state_d   = ST_RUN;
            seq_cnt_d = '0;
          end else begin
            seq_cnt_d = seq_cnt_q + SeqW'(1);
          end
        end
        ST_RUN: begin
          seq_cnt_d = '0;
        end
        default: begin
          state_d   = ST_HOLD;
          seq_cnt_d = '0;
        end
      endcase
    end
  end

  // Fetch needs the switch high both before and after the edge: it rises one edge after
  // the debounced switch rises, but drops on the very edge the switch falls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_HOLD;
      seq_cnt_q      <= '0;
      soc_rst_no     <= 1'b0;
      soc_fetch_en_o <= 1'b0;
      rst_count_o    <= '0;
    end else begin
      state_q        <= state_d;
      seq_cnt_q      <= seq_cnt_d;
      soc_rst_no     <= (state_d != ST_HOLD);
      soc_fetch_en_o <= (state_d == ST_RUN) & db_q[1] & db_d[1];
      if (btn_rise && (rst_count_o != 8'hff)) begin
        rst_count_o <= rst_count_o + 8'd1;
      end
    end
  end

  assign state_o = state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rtc_cnt_q <= '0;
      rtc_clk_o <= 1'b0;
    end else if (rtc_cnt_q == RtcW'(RtcDiv)) begin
      rtc_cnt_q <= '0;
      rtc_clk_o <= ~rtc_clk_o;
    end else begin
      rtc_cnt_q <= rtc_cnt_q + RtcW'(1);
    end
  end

endmodule
